// File: rtl/shift_register_pkg.sv
// rtl/shift_register_pkg.sv - shared constants and helpers for framed shift registers
//
// Purpose : shift-direction encodings and frame-counter sizing helper used by
//           shift_register_framed and later serial blocks.
// Contents: SHIFT_TOWARD_MSB / SHIFT_TOWARD_LSB direction values,
//           frame_cnt_width(width, lanes) -> bits needed to count shifts per frame.
package shift_register_pkg;

    localparam logic SHIFT_TOWARD_MSB = 1'b0;
    localparam logic SHIFT_TOWARD_LSB = 1'b1;

    // A frame takes width/lanes shifts; never return less than one bit so a
    // two-shift frame still has a real counter.
    function automatic int frame_cnt_width(input int width, input int lanes);
        int shifts;
        shifts = width / lanes;
        return (shifts <= 2) ? 1 : $clog2(shifts);
    endfunction

endpackage

// File: rtl/frame_slot.sv
// rtl/frame_slot.sv - single-entry holding register with valid/ready and sticky overflow
//
// Purpose : holds one captured word until the consumer takes it. A capture that
//           arrives while the slot is still occupied (and not being emptied this
//           cycle) is dropped and flags overflow.
// Optional: SHIFT_REGISTER_FRAMED_PARITY_EN adds o_parity (XOR of the held word).
// Ports   : clk, reset (async, active-high)
//           i_capture        - a new word is offered this cycle
//           i_word[WIDTH]    - word to capture
//           i_ready          - consumer accepts o_data when o_valid
//           i_clear_overflow - synchronous clear of the sticky overflow flag
//           o_valid, o_data[WIDTH], o_overflow, (o_parity)
module frame_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_capture,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    input  logic             i_clear_overflow,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
    output logic             o_parity,
`endif
    output logic             o_overflow
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_overflow;
    logic             w_transfer;
    logic             w_accept;

    assign w_transfer = r_valid && i_ready;
    // The slot can take a new word when empty or when it is being emptied now.
    assign w_accept   = i_capture && (!r_valid || w_transfer);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data  <= i_word;
                r_valid <= 1'b1;
            end else if (w_transfer) begin
                r_valid <= 1'b0;
            end

            if (i_clear_overflow) begin
                r_overflow <= 1'b0;
            end else if (i_capture && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^i_word;
        end
    end

    assign o_parity = r_parity;
`endif

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/shift_register_framed.sv
// rtl/shift_register_framed.sv - multi-lane bidirectional shift register with word framing
//
// Purpose : WIDTH-bit register shifting LANES bits per enabled cycle in either
//           direction, with parallel load. Every WIDTH/LANES shifts the post-shift
//           value is offered to a frame_slot for valid/ready hand-off; shifting
//           never stalls on the consumer.
// Optional: SHIFT_REGISTER_FRAMED_PARITY_EN adds output frame_parity.
// Ports   : clk, reset (async, active-high)
//           serial_in[LANES], shift_enable, shift_dir (0 toward MSB, 1 toward LSB)
//           load, load_data[WIDTH]          - parallel load, wins over shift
//           stored_data[WIDTH], serial_out[LANES]
//           frame_valid, frame_ready, frame_data[WIDTH], frame_overflow, (frame_parity)
module shift_register_framed
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] serial_in,
    input  logic             shift_enable,
    input  logic             shift_dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] stored_data,
    output logic [LANES-1:0] serial_out,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [WIDTH-1:0] frame_data,
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
    output logic             frame_parity,
`endif
    output logic             frame_overflow
);

    localparam int SHIFTS_PER_FRAME = WIDTH / LANES;
    localparam int CW               = frame_cnt_width(WIDTH, LANES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(SHIFTS_PER_FRAME - 1);

    if ((WIDTH % LANES) != 0) begin : g_bad_lanes
        $error("shift_register_framed: WIDTH must be a multiple of LANES");
    end
    if (LANES < 1 || LANES > WIDTH / 2) begin : g_bad_lane_count
        $error("shift_register_framed: LANES must be in 1..WIDTH/2");
    end

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_shifted;
    logic             w_shift;
    logic             w_complete;

    assign w_shift = shift_enable && !load;

    always_comb begin
        w_shifted = r_shift;
        if (shift_dir == SHIFT_TOWARD_LSB) begin
            w_shifted = {serial_in, r_shift[WIDTH-1:LANES]};
        end else begin
            w_shifted = {r_shift[WIDTH-LANES-1:0], serial_in};
        end
    end

    // The shift that lands on the last count closes a frame; the slot captures
    // the value the register is about to take, not the current one.
    assign w_complete = w_shift && (r_count == LAST_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (load) begin
            r_shift <= load_data;
            r_count <= '0;
        end else if (shift_enable) begin
            r_shift <= w_shifted;
            r_count <= (r_count == LAST_COUNT) ? '0 : r_count + 1'b1;
        end
    end

    assign stored_data = r_shift;
    assign serial_out  = (shift_dir == SHIFT_TOWARD_MSB) ? r_shift[WIDTH-1 -: LANES]
                                                         : r_shift[LANES-1:0];

    frame_slot #(
        .WIDTH(WIDTH)
    ) u_frame_slot (
        .clk              (clk),
        .reset            (reset),
        .i_capture        (w_complete),
        .i_word           (w_shifted),
        .i_ready          (frame_ready),
        .i_clear_overflow (load),
        .o_valid          (frame_valid),
        .o_data           (frame_data),
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
        .o_parity         (frame_parity),
`endif
        .o_overflow       (frame_overflow)
    );

endmodule

// File: tb/tb_shift_register_framed.sv
// tb/tb_shift_register_framed.sv - self-checking bench for shift_register_framed
module tb_shift_register_framed;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT A: WIDTH=8, LANES=1
    logic       a_sin, a_en, a_dir, a_load, a_ready;
    logic [7:0] a_load_data, a_stored, a_frame_data;
    logic       a_sout, a_valid, a_ovf;
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
    logic       a_parity;
`endif

    // DUT B: WIDTH=8, LANES=2
    logic [1:0] b_sin, b_sout;
    logic       b_en, b_dir, b_load, b_ready;
    logic [7:0] b_load_data, b_stored, b_frame_data;
    logic       b_valid, b_ovf;
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
    logic       b_parity;
`endif

    shift_register_framed #(.WIDTH(8), .LANES(1)) u_dut_a (
        .clk(clk), .reset(reset), .serial_in(a_sin), .shift_enable(a_en),
        .shift_dir(a_dir), .load(a_load), .load_data(a_load_data),
        .stored_data(a_stored), .serial_out(a_sout), .frame_valid(a_valid),
        .frame_ready(a_ready), .frame_data(a_frame_data),
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
        .frame_parity(a_parity),
`endif
        .frame_overflow(a_ovf)
    );

    shift_register_framed #(.WIDTH(8), .LANES(2)) u_dut_b (
        .clk(clk), .reset(reset), .serial_in(b_sin), .shift_enable(b_en),
        .shift_dir(b_dir), .load(b_load), .load_data(b_load_data),
        .stored_data(b_stored), .serial_out(b_sout), .frame_valid(b_valid),
        .frame_ready(b_ready), .frame_data(b_frame_data),
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
        .frame_parity(b_parity),
`endif
        .frame_overflow(b_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of DUT A and scoreboard of frames it should hand over.
    logic [7:0] m_reg, m_data;
    int         m_cnt;
    logic       m_valid, m_ovf;
    logic [7:0] exp_q[$];

    task automatic model_reset();
        m_reg = 8'h00; m_data = 8'h00; m_cnt = 0; m_valid = 1'b0; m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic step_a(input logic sin, input logic en, input logic dir,
                          input logic ld, input logic [7:0] ldd, input logic rdy);
        logic       xfer;
        logic [7:0] e;
        a_sin = sin; a_en = en; a_dir = dir; a_load = ld; a_load_data = ldd; a_ready = rdy;
        #1;
        check("a_serial_out", {31'd0, a_sout}, {31'd0, (dir ? m_reg[0] : m_reg[7])});
        if (a_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("a_sb_unexpected_frame", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("a_sb_frame_data", {24'd0, a_frame_data}, {24'd0, e});
            end
        end
        @(posedge clk);
        #1;
        xfer = m_valid && rdy;
        if (ld) begin
            m_reg = ldd; m_cnt = 0; m_ovf = 1'b0;
            if (xfer) m_valid = 1'b0;
        end else if (en) begin
            m_reg = dir ? {sin, m_reg[7:1]} : {m_reg[6:0], sin};
            if (m_cnt == 7) begin
                m_cnt = 0;
                if (!m_valid || xfer) begin
                    m_data = m_reg; m_valid = 1'b1; exp_q.push_back(m_reg);
                end else begin
                    m_ovf = 1'b1;
                end
            end else begin
                m_cnt++;
                if (xfer) m_valid = 1'b0;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        check("a_stored", {24'd0, a_stored}, {24'd0, m_reg});
        check("a_valid", {31'd0, a_valid}, {31'd0, m_valid});
        check("a_overflow", {31'd0, a_ovf}, {31'd0, m_ovf});
        check("a_frame_data", {24'd0, a_frame_data}, {24'd0, m_data});
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
        check("a_parity", {31'd0, a_parity}, {31'd0, ^m_data});
`endif
    endtask

    task automatic shift_word_a(input logic [7:0] w, input logic rdy_last);
        for (int i = 7; i >= 0; i--) step_a(w[i], 1'b1, 1'b0, 1'b0, 8'h00, (i == 0) ? rdy_last : 1'b0);
    endtask

    task automatic drain_a();
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [7:0] b_exp [4];
        logic [1:0] b_in  [4];
        b_exp = '{8'h40, 8'h90, 8'hE4, 8'h39};
        b_in  = '{2'b01, 2'b10, 2'b11, 2'b00};

        reset = 1'b1;
        a_sin = 0; a_en = 0; a_dir = 0; a_load = 0; a_load_data = 0; a_ready = 0;
        b_sin = 0; b_en = 0; b_dir = 0; b_load = 0; b_load_data = 0; b_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stored", {24'd0, a_stored}, 32'd0);
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_frame_data", {24'd0, a_frame_data}, 32'd0);
        check("rst_overflow", {31'd0, a_ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame, LANES=1, dir 0.
        shift_word_a(8'hB2, 1'b0);
        check("b2_frame_data", {24'd0, a_frame_data}, 32'hB2);
        check("b2_stored", {24'd0, a_stored}, 32'hB2);
        check("b2_valid", {31'd0, a_valid}, 32'd1);
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
        check("b2_parity", {31'd0, a_parity}, 32'd0);
`endif
        drain_a();

        // Overflow: consumer stalled across two frames; load clears overflow only.
        shift_word_a(8'h3C, 1'b0);
        shift_word_a(8'hC3, 1'b0);
        check("ovf_set", {31'd0, a_ovf}, 32'd1);
        check("ovf_first_kept", {24'd0, a_frame_data}, 32'h3C);
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("ovf_cleared_by_load", {31'd0, a_ovf}, 32'd0);
        check("ovf_valid_kept", {31'd0, a_valid}, 32'd1);
        drain_a();

        // Ready pulsed exactly on the second completing shift.
        shift_word_a(8'h96, 1'b0);
        shift_word_a(8'h69, 1'b1);
        check("pulse_valid", {31'd0, a_valid}, 32'd1);
        check("pulse_next_frame", {24'd0, a_frame_data}, 32'h69);
        check("pulse_no_ovf", {31'd0, a_ovf}, 32'd0);
        drain_a();

        // Load beats shift and restarts the frame count.
        step_a(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
        check("load_stored", {24'd0, a_stored}, 32'hA5);
        for (int i = 0; i < 7; i++) step_a(i[0], 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check("load_no_early_frame", {31'd0, a_valid}, 32'd0);
        step_a(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check("load_frame_after_8", {31'd0, a_valid}, 32'd1);
        drain_a();

        // Asynchronous reset mid-frame with a frame pending.
        shift_word_a(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        a_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_stored", {24'd0, a_stored}, 32'd0);
        check("arst_valid", {31'd0, a_valid}, 32'd0);
        check("arst_frame_data", {24'd0, a_frame_data}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 7; i >= 1; i--) step_a(i[0] ^ i[1], 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("arst_no_early_frame", {31'd0, a_valid}, 32'd0);
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("arst_frame_after_8", {31'd0, a_valid}, 32'd1);
        drain_a();

        // LANES=2, dir 1.
        b_dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_sin = b_in[i]; b_en = 1'b1;
            @(posedge clk);
            #1;
            check("b_stored", {24'd0, b_stored}, {24'd0, b_exp[i]});
            check("b_serial_out", {30'd0, b_sout}, {30'd0, b_exp[i][1:0]});
            check("b_valid", {31'd0, b_valid}, (i == 3) ? 32'd1 : 32'd0);
        end
        b_en = 1'b0;
        check("b_frame_data", {24'd0, b_frame_data}, 32'h39);
        check("b_overflow", {31'd0, b_ovf}, 32'd0);
`ifdef SHIFT_REGISTER_FRAMED_PARITY_EN
        check("b_parity", {31'd0, b_parity}, 32'd0);
`endif

        // Random mix of shifts, direction changes, loads and consumer stalls.
        for (int i = 0; i < 200; i++) begin
            step_a(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                   ($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 2) == 0));
        end
        drain_a();
        drain_a();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
